// File: rtl/ex_stage.sv
// Execute stage: ALU, jump-link, address generation, HI/LO with 1-cycle multiply and iterative divide.
// Optional macro EX_OVERFLOW_TRAP_EN adds signed-overflow detection for ADD/SUB/ADDI (port ov_exc).
module ex_stage #(
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] input_addr,
    input  logic [31:0] input_inst,
    input  logic [4:0]  input_write_reg,
    input  logic [31:0] input_rsvalue,
    input  logic [31:0] input_rtvalue,
    input  logic [31:0] input_imm,
    output logic [31:0] output_addr,
    output logic [31:0] output_inst,
    output logic [4:0]  output_write_reg,
    output logic        output_write_en,
    output logic [31:0] output_write_data,
    output logic [31:0] output_mem_addr,
    output logic [31:0] output_mem_wdata,
    output logic        stall_req
`ifdef EX_OVERFLOW_TRAP_EN
    ,
    output logic        ov_exc
`endif
);

    localparam int         STEPS     = 32 / DIV_BITS_PER_CYCLE;
    localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;

    logic [5:0]  op_s, funct_s;
    logic [4:0]  shamt_s;
    logic        is_rtype_s, is_div_s, is_signed_div_s;
    logic [31:0] rs_s, rt_s, imm_s;
    logic [31:0] sum_rr_s, diff_rr_s, sum_ri_s;
    logic [31:0] result_s;
    logic        wen_s;
    logic [63:0] prod_signed_s, prod_unsigned_s;

    div_state_e  state_q, state_d;
    logic [4:0]  counter_q, counter_d;
    logic [31:0] rem_q, rem_d, quot_q, quot_d, divisor_q, divisor_d, rs_lat_q, rs_lat_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [32:0] rem_step_s;
    logic [31:0] quot_step_s;
    logic [31:0] div_lo_s, div_hi_s;
    logic        stall_s;

    assign op_s            = input_inst[31:26];
    assign funct_s         = input_inst[5:0];
    assign shamt_s         = input_inst[10:6];
    assign rs_s            = input_rsvalue;
    assign rt_s            = input_rtvalue;
    assign imm_s           = input_imm;
    assign is_rtype_s      = (op_s == 6'h00);
    assign is_div_s        = is_rtype_s && ((funct_s == 6'h1A) || (funct_s == 6'h1B));
    assign is_signed_div_s = is_rtype_s && (funct_s == 6'h1A);
    assign sum_rr_s        = rs_s + rt_s;
    assign diff_rr_s       = rs_s - rt_s;
    assign sum_ri_s        = rs_s + imm_s;
    assign prod_signed_s   = $signed({{32{rs_s[31]}}, rs_s}) * $signed({{32{rt_s[31]}}, rt_s});
    assign prod_unsigned_s = {32'h0, rs_s} * {32'h0, rt_s};

    assign output_addr      = input_addr;
    assign output_inst      = input_inst;
    assign output_write_reg = input_write_reg;
    assign output_mem_addr  = sum_ri_s;
    assign output_mem_wdata = rt_s;

    // Result and write-enable decode
    always_comb begin
        result_s = 32'h0;
        wen_s    = 1'b0;
        case (op_s)
            6'h00: begin
                wen_s = 1'b1;
                case (funct_s)
                    6'h20, 6'h21: result_s = sum_rr_s;
                    6'h22, 6'h23: result_s = diff_rr_s;
                    6'h24: result_s = rs_s & rt_s;
                    6'h25: result_s = rs_s | rt_s;
                    6'h26: result_s = rs_s ^ rt_s;
                    6'h27: result_s = ~(rs_s | rt_s);
                    6'h2A: result_s = {31'h0, $signed(rs_s) < $signed(rt_s)};
                    6'h2B: result_s = {31'h0, rs_s < rt_s};
                    6'h00: result_s = rt_s << shamt_s;
                    6'h02: result_s = rt_s >> shamt_s;
                    6'h03: result_s = $signed(rt_s) >>> shamt_s;
                    6'h10: result_s = hi_q;
                    6'h12: result_s = lo_q;
                    6'h09: result_s = input_addr + 32'd8;
                    default: wen_s = 1'b0;
                endcase
            end
            6'h03:        begin result_s = input_addr + 32'd8;  wen_s = 1'b1; end
            6'h08, 6'h09: begin result_s = sum_ri_s;            wen_s = 1'b1; end
            6'h0A:        begin result_s = {31'h0, $signed(rs_s) < $signed(imm_s)}; wen_s = 1'b1; end
            6'h0B:        begin result_s = {31'h0, rs_s < imm_s}; wen_s = 1'b1; end
            6'h0C:        begin result_s = rs_s & imm_s;        wen_s = 1'b1; end
            6'h0D:        begin result_s = rs_s | imm_s;        wen_s = 1'b1; end
            6'h0E:        begin result_s = rs_s ^ imm_s;        wen_s = 1'b1; end
            6'h0F:        begin result_s = imm_s;               wen_s = 1'b1; end
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: begin result_s = 32'h0; wen_s = 1'b1; end
            default:      begin result_s = 32'h0;               wen_s = 1'b0; end
        endcase
    end

    assign output_write_data = result_s;

`ifdef EX_OVERFLOW_TRAP_EN
    logic ov_s;

    // Signed overflow for the trapping add/sub forms
    always_comb begin
        ov_s = 1'b0;
        if (is_rtype_s && (funct_s == 6'h20)) begin
            ov_s = (rs_s[31] == rt_s[31]) && (sum_rr_s[31] != rs_s[31]);
        end else if (is_rtype_s && (funct_s == 6'h22)) begin
            ov_s = (rs_s[31] != rt_s[31]) && (diff_rr_s[31] != rs_s[31]);
        end else if (op_s == 6'h08) begin
            ov_s = (rs_s[31] == imm_s[31]) && (sum_ri_s[31] != rs_s[31]);
        end else begin
            ov_s = 1'b0;
        end
    end

    assign ov_exc          = ov_s;
    assign output_write_en = !reset && wen_s && !ov_s;
`else
    assign output_write_en = !reset && wen_s;
`endif

    // Restoring divide: DIV_BITS_PER_CYCLE quotient bits per BUSY cycle
    always_comb begin
        rem_step_s  = {1'b0, rem_q};
        quot_step_s = quot_q;
        for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
            rem_step_s  = {rem_step_s[31:0], quot_step_s[31]};
            quot_step_s = {quot_step_s[30:0], 1'b0};
            if (rem_step_s >= {1'b0, divisor_q}) begin
                rem_step_s     = rem_step_s - {1'b0, divisor_q};
                quot_step_s[0] = 1'b1;
            end else begin
                quot_step_s[0] = 1'b0;
            end
        end
    end

    assign div_lo_s = dbz_q ? 32'hFFFF_FFFF : (qneg_q ? (32'h0 - quot_q) : quot_q);
    assign div_hi_s = dbz_q ? rs_lat_q      : (rneg_q ? (32'h0 - rem_q)  : rem_q);

    // Divider next-state and stall request
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        rs_lat_d  = rs_lat_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dbz_d     = dbz_q;
        stall_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_div_s && !flush) begin
                    stall_s   = 1'b1;
                    quot_d    = (is_signed_div_s && rs_s[31]) ? (32'h0 - rs_s) : rs_s;
                    divisor_d = (is_signed_div_s && rt_s[31]) ? (32'h0 - rt_s) : rt_s;
                    qneg_d    = is_signed_div_s && (rs_s[31] ^ rt_s[31]);
                    rneg_d    = is_signed_div_s && rs_s[31];
                    dbz_d     = (rt_s == 32'h0);
                    rs_lat_d  = rs_s;
                    rem_d     = 32'h0;
                    counter_d = 5'd0;
                    state_d   = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                stall_s   = 1'b1;
                rem_d     = rem_step_s[31:0];
                quot_d    = quot_step_s;
                counter_d = counter_q + 5'd1;
                if (flush) begin
                    state_d = IDLE;
                end else if (counter_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall_req = !reset && stall_s;

    // HI/LO write selection: flush > divide result > MT/MULT
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (flush) begin
            hi_d = hi_q;
        end else if (state_q == DONE) begin
            hi_d = div_hi_s;
            lo_d = div_lo_s;
        end else if (is_rtype_s) begin
            case (funct_s)
                6'h11:   hi_d = rs_s;
                6'h13:   lo_d = rs_s;
                6'h18:   {hi_d, lo_d} = prod_signed_s;
                6'h19:   {hi_d, lo_d} = prod_unsigned_s;
                default: hi_d = hi_q;
            endcase
        end else begin
            hi_d = hi_q;
        end
    end

    // State, divider datapath and HI/LO registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= 5'd0;
            rem_q     <= 32'h0;
            quot_q    <= 32'h0;
            divisor_q <= 32'h0;
            rs_lat_q  <= 32'h0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= 32'h0;
            lo_q      <= 32'h0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            rs_lat_q  <= rs_lat_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed table-driven bench for ex_stage plus hand sequences for divide, flush and reset.
module tb_ex_stage;

    logic        clock = 1'b0;
    logic        reset, flush;
    logic [31:0] input_addr, input_inst, input_rsvalue, input_rtvalue, input_imm;
    logic [4:0]  input_write_reg;
    logic [31:0] output_addr, output_inst, output_write_data, output_mem_addr, output_mem_wdata;
    logic [4:0]  output_write_reg;
    logic        output_write_en, stall_req;
`ifdef EX_OVERFLOW_TRAP_EN
    logic        ov_exc;
`endif

    int total = 0;
    int bad   = 0;

    ex_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .input_addr(input_addr), .input_inst(input_inst), .input_write_reg(input_write_reg),
        .input_rsvalue(input_rsvalue), .input_rtvalue(input_rtvalue), .input_imm(input_imm),
        .output_addr(output_addr), .output_inst(output_inst), .output_write_reg(output_write_reg),
        .output_write_en(output_write_en), .output_write_data(output_write_data),
        .output_mem_addr(output_mem_addr), .output_mem_wdata(output_mem_wdata),
        .stall_req(stall_req)
`ifdef EX_OVERFLOW_TRAP_EN
        , .ov_exc(ov_exc)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] inst, addr, rs, rt, imm;
        logic        wen;
        logic [31:0] data;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] rt_op(input logic [5:0] funct, input logic [4:0] sh);
        return {6'h00, 15'h0, sh, funct};
    endfunction

    function automatic logic [31:0] it_op(input logic [5:0] op);
        return {op, 26'h0};
    endfunction

    task automatic add(input string n, input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic wen, input logic [31:0] data);
        vec_t v;
        v.name = n; v.inst = inst; v.addr = addr; v.rs = rs; v.rt = rt; v.imm = imm;
        v.wen = wen; v.data = data;
        vq.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
        input_inst = inst; input_rsvalue = rs; input_rtvalue = rt;
    endtask

    task automatic run_div(input string n, input logic [31:0] inst, input logic [31:0] rs,
                           input logic [31:0] rt, input int exp_cycles,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int cnt;
        cnt = 0;
        apply(inst, rs, rt);
        #1;
        while (stall_req === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clock); #1;
        end
        chk({n, " stall cycles"}, 32'(cnt), 32'(exp_cycles));
        apply(rt_op(6'h12, 5'd0), 32'h0, 32'h0);
        @(negedge clock); #1;
        chk({n, " LO"}, output_write_data, exp_lo);
        chk({n, " no restart"}, {31'h0, stall_req}, 32'h0);
        apply(rt_op(6'h10, 5'd0), 32'h0, 32'h0);
        @(negedge clock); #1;
        chk({n, " HI"}, output_write_data, exp_hi);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        input_addr = 32'h0; input_write_reg = 5'd0; input_imm = 32'h0;
        apply(rt_op(6'h1A, 5'd0), 32'd9, 32'd2);

        // Reset behaviour: no stall and no write even with a DIV presented
        @(negedge clock);
        chk("reset stall", {31'h0, stall_req}, 32'h0);
        apply(rt_op(6'h21, 5'd0), 32'd1, 32'd1);
        #1;
        chk("reset wen", {31'h0, output_write_en}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        apply(rt_op(6'h10, 5'd0), 32'h0, 32'h0);
        @(negedge clock);
        chk("reset HI", output_write_data, 32'h0);
        apply(rt_op(6'h12, 5'd0), 32'h0, 32'h0);
        @(negedge clock);
        chk("reset LO", output_write_data, 32'h0);

        add("addu",  rt_op(6'h21, 5'd0), 32'h0,   32'hFFFF_FFFF, 32'h2,         32'h0, 1'b1, 32'h1);
        add("subu",  rt_op(6'h23, 5'd0), 32'h0,   32'h5,         32'h7,         32'h0, 1'b1, 32'hFFFF_FFFE);
        add("and",   rt_op(6'h24, 5'd0), 32'h0,   32'hF0F0,      32'hFF00,      32'h0, 1'b1, 32'hF000);
        add("or",    rt_op(6'h25, 5'd0), 32'h0,   32'hF0F0,      32'hFF00,      32'h0, 1'b1, 32'hFFF0);
        add("xor",   rt_op(6'h26, 5'd0), 32'h0,   32'hF0F0,      32'hFF00,      32'h0, 1'b1, 32'h0FF0);
        add("nor",   rt_op(6'h27, 5'd0), 32'h0,   32'h0,         32'h0,         32'h0, 1'b1, 32'hFFFF_FFFF);
        add("slt",   rt_op(6'h2A, 5'd0), 32'h0,   32'h8000_0000, 32'h1,         32'h0, 1'b1, 32'h1);
        add("sltu",  rt_op(6'h2B, 5'd0), 32'h0,   32'h8000_0000, 32'h1,         32'h0, 1'b1, 32'h0);
        add("sll",   rt_op(6'h00, 5'd31), 32'h0,  32'h0,         32'h1,         32'h0, 1'b1, 32'h8000_0000);
        add("srl",   rt_op(6'h02, 5'd4), 32'h0,   32'h0,         32'h8000_0000, 32'h0, 1'b1, 32'h0800_0000);
        add("sra",   rt_op(6'h03, 5'd4), 32'h0,   32'h0,         32'h8000_0000, 32'h0, 1'b1, 32'hF800_0000);
        add("addiu", it_op(6'h09), 32'h0, 32'h10,        32'h0, 32'hFFFF_FFFF, 1'b1, 32'hF);
        add("slti",  it_op(6'h0A), 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h1,         1'b1, 32'h1);
        add("sltiu", it_op(6'h0B), 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h1,         1'b1, 32'h0);
        add("andi",  it_op(6'h0C), 32'h0, 32'h1234,      32'h0, 32'h00FF,      1'b1, 32'h34);
        add("ori",   it_op(6'h0D), 32'h0, 32'h1200,      32'h0, 32'h0034,      1'b1, 32'h1234);
        add("xori",  it_op(6'h0E), 32'h0, 32'hFF,        32'h0, 32'h0F,        1'b1, 32'hF0);
        add("lui",   it_op(6'h0F), 32'h0, 32'h5555,      32'h0, 32'h1234_0000, 1'b1, 32'h1234_0000);
        add("jal",   it_op(6'h03), 32'h100, 32'h0, 32'h0, 32'h0, 1'b1, 32'h108);
        add("jalr",  rt_op(6'h09, 5'd0), 32'h200, 32'h0, 32'h0, 32'h0, 1'b1, 32'h208);
        add("lw",    it_op(6'h23), 32'h0, 32'h1000, 32'h0, 32'h4, 1'b1, 32'h0);
        add("sw",    it_op(6'h2B), 32'h0, 32'h1000, 32'h0, 32'h4, 1'b0, 32'h0);
        add("beq",   it_op(6'h04), 32'h0, 32'h1,    32'h1, 32'h0, 1'b0, 32'h0);
        add("mthi",  rt_op(6'h11, 5'd0), 32'h0, 32'hAAAA_5555, 32'h0, 32'h0, 1'b0, 32'h0);
        add("mtlo",  rt_op(6'h13, 5'd0), 32'h0, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 32'h0);
        add("mfhi1", rt_op(6'h10, 5'd0), 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hAAAA_5555);
        add("mflo1", rt_op(6'h12, 5'd0), 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1234_5678);
        add("mult",  rt_op(6'h18, 5'd0), 32'h0, 32'hFFFF_FFFD, 32'h7, 32'h0, 1'b0, 32'h0);
        add("mflo2", rt_op(6'h12, 5'd0), 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFEB);
        add("mfhi2", rt_op(6'h10, 5'd0), 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        add("multu", rt_op(6'h19, 5'd0), 32'h0, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0, 32'h0);
        add("mfhi3", rt_op(6'h10, 5'd0), 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1);
        add("mflo3", rt_op(6'h12, 5'd0), 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFE);
        add("sub",   rt_op(6'h22, 5'd0), 32'h0, 32'h3, 32'h5, 32'h0, 1'b1, 32'hFFFF_FFFE);
        add("addi",  it_op(6'h08), 32'h0, 32'h5, 32'h0, 32'h3, 1'b1, 32'h8);
`ifdef EX_OVERFLOW_TRAP_EN
        add("add ovf", rt_op(6'h20, 5'd0), 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h0);
`else
        add("add ovf", rt_op(6'h20, 5'd0), 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b1, 32'h8000_0000);
`endif

        foreach (vq[i]) begin
            input_inst = vq[i].inst; input_addr = vq[i].addr;
            input_rsvalue = vq[i].rs; input_rtvalue = vq[i].rt; input_imm = vq[i].imm;
            @(negedge clock);
            chk({vq[i].name, " wen"}, {31'h0, output_write_en}, {31'h0, vq[i].wen});
            if (vq[i].wen) begin
                chk({vq[i].name, " data"}, output_write_data, vq[i].data);
            end
`ifdef EX_OVERFLOW_TRAP_EN
            chk({vq[i].name, " ov"}, {31'h0, ov_exc}, {31'h0, (vq[i].name == "add ovf")});
`endif
        end

        // Pass-through and address generation on a store
        input_inst = it_op(6'h2B) | 32'h0000_0BEE; input_addr = 32'h0040_0010; input_write_reg = 5'd17;
        input_rsvalue = 32'h0000_1000; input_rtvalue = 32'hCAFE_F00D; input_imm = 32'hFFFF_FFF8;
        @(negedge clock);
        chk("mem_addr",  output_mem_addr,  32'h0000_0FF8);
        chk("mem_wdata", output_mem_wdata, 32'hCAFE_F00D);
        chk("addr pass", output_addr,      32'h0040_0010);
        chk("inst pass", output_inst,      32'hAC00_0BEE);
        chk("wreg pass", {27'h0, output_write_reg}, 32'd17);
        input_imm = 32'h0;

        run_div("div -7/2",  rt_op(6'h1A, 5'd0), 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("divu 100/7", rt_op(6'h1B, 5'd0), 32'd100, 32'd7, 33, 32'd14, 32'd2);
        run_div("divu 5/0",  rt_op(6'h1B, 5'd0), 32'd5, 32'd0, 33, 32'hFFFF_FFFF, 32'd5);

        // Flush at BUSY cycle 10 leaves HI/LO from the 5/0 divide
        apply(rt_op(6'h1B, 5'd0), 32'd50, 32'd3);
        #1;
        chk("flush issue stall", {31'h0, stall_req}, 32'h1);
        repeat (10) @(negedge clock);
        #1;
        chk("flush busy stall", {31'h0, stall_req}, 32'h1);
        flush = 1'b1;
        apply(rt_op(6'h12, 5'd0), 32'h0, 32'h0);
        @(negedge clock); #1;
        flush = 1'b0;
        chk("flush stall drop", {31'h0, stall_req}, 32'h0);
        chk("flush LO kept", output_write_data, 32'hFFFF_FFFF);
        apply(rt_op(6'h10, 5'd0), 32'h0, 32'h0);
        @(negedge clock); #1;
        chk("flush HI kept", output_write_data, 32'd5);
        chk("flush idle", {31'h0, stall_req}, 32'h0);

        // Reset mid-BUSY clears HI/LO and the divider
        apply(rt_op(6'h1B, 5'd0), 32'd100, 32'd7);
        repeat (5) @(negedge clock);
        #1;
        chk("pre-reset stall", {31'h0, stall_req}, 32'h1);
        reset = 1'b1;
        #1;
        chk("mid reset stall", {31'h0, stall_req}, 32'h0);
        @(negedge clock); #1;
        reset = 1'b0;
        apply(rt_op(6'h12, 5'd0), 32'h0, 32'h0);
        @(negedge clock); #1;
        chk("post reset LO", output_write_data, 32'h0);
        chk("post reset stall", {31'h0, stall_req}, 32'h0);
        apply(rt_op(6'h10, 5'd0), 32'h0, 32'h0);
        @(negedge clock); #1;
        chk("post reset HI", output_write_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
